pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_pkg.sv | 36 +++
 rtl/branch_lut.sv | 36 +++
 rtl/pc_unit.sv | 108 ++++++++++
 tb/tb_pc_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit.
//   PC_W_DEF   default program-counter width (1024-entry program memory)
//   LUT_N_DEF  default number of branch-target table entries
//   branch_cond_t  branch condition encoding (EQ, LT, LTE, ALWAYS)
//   state_t        sequencer states (IDLE, RUN, HALTED)
//   cond_met()     evaluates a branch condition against the ALU flags
package pc_pkg;

    localparam int PC_W_DEF  = 10;
    localparam int LUT_N_DEF = 16;

    typedef enum logic [1:0] {
        EQ     = 2'b00,
        LT     = 2'b01,
        LTE    = 2'b10,
        ALWAYS = 2'b11
    } branch_cond_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } state_t;

    function automatic logic cond_met(branch_cond_t c, logic eq, logic lt);
        logic r;
        case (c)
            EQ:      r = eq;
            LT:      r = lt;
            LTE:     r = eq | lt;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/branch_lut.sv
// Branch-target table: LUT_N entries of PC_W bits.
//   clk, reset_n   clock and asynchronous active-low reset (clears all entries)
//   we/waddr/wdata synchronous write port
//   raddr/rdata    combinational read port
// A write and a read of the same entry in one cycle returns the old value;
// the new contents appear after the edge.
module branch_lut
    import pc_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int LUT_N = LUT_N_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     we,
    input  logic [$clog2(LUT_N)-1:0] waddr,
    input  logic [PC_W-1:0]          wdata,
    input  logic [$clog2(LUT_N)-1:0] raddr,
    output logic [PC_W-1:0]          rdata
);

    logic [PC_W-1:0] mem [LUT_N];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LUT_N; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pc_unit.sv
// Program-counter sequencer with a branch-target table.
//   clk, reset_n         clock, asynchronous active-low reset
//   start                begin execution at pc 0 (from IDLE or HALTED)
//   stall                freeze pc/state/counter for this cycle
//   branch_en/branch_cond/equal/lessThan/lut_idx  branch request; target = lut[lut_idx]
//   lut_we/lut_waddr/lut_wdata                     table write port (always active)
//   halt_req             current instruction is HALT
//   pc                   fetch address
//   running / done       state decodes (RUN / HALTED)
//   cycle_count          saturating count of non-stalled RUN cycles since start
//   dbg_state            current FSM state, for observation
module pc_unit
    import pc_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int LUT_N = LUT_N_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     stall,
    input  logic                     branch_en,
    input  logic [1:0]               branch_cond,
    input  logic                     equal,
    input  logic                     lessThan,
    input  logic [$clog2(LUT_N)-1:0] lut_idx,
    input  logic                     lut_we,
    input  logic [$clog2(LUT_N)-1:0] lut_waddr,
    input  logic [PC_W-1:0]          lut_wdata,
    input  logic                     halt_req,
    output logic [PC_W-1:0]          pc,
    output logic                     running,
    output logic                     done,
    output logic [15:0]              cycle_count,
    output state_t                   dbg_state
);

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic [15:0]     cnt_nxt;
    logic [PC_W-1:0] lut_rdata;
    logic            taken;

    branch_lut #(
        .PC_W  (PC_W),
        .LUT_N (LUT_N)
    ) u_lut (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (lut_we),
        .waddr   (lut_waddr),
        .wdata   (lut_wdata),
        .raddr   (lut_idx),
        .rdata   (lut_rdata)
    );

    assign taken = branch_en & cond_met(branch_cond_t'(branch_cond), equal, lessThan);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pc          <= '0;
            cycle_count <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            cycle_count <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = cycle_count;
        case (state)
            IDLE, HALTED: begin
                if (start) begin
                    state_nxt = RUN;
                    pc_nxt    = '0;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                if (!stall) begin
                    // The halting cycle is itself counted.
                    cnt_nxt = (cycle_count == 16'hFFFF) ? cycle_count : cycle_count + 16'd1;
                    if (halt_req) begin
                        state_nxt = HALTED;
                    end else if (taken) begin
                        pc_nxt = lut_rdata;
                    end else begin
                        pc_nxt = pc + PC_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                pc_nxt    = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign running   = (state == RUN);
    assign done      = (state == HALTED);
    assign dbg_state = state;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  localparam int PC_W  = 10;
  localparam int LUT_N = 16;
  localparam int PC_MOD = 1 << PC_W;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        stall;
  logic        branch_en;
  logic [1:0]  branch_cond;
  logic        equal;
  logic        less_than;
  logic [3:0]  lut_idx;
  logic        lut_we;
  logic [3:0]  lut_waddr;
  logic [9:0]  lut_wdata;
  logic        halt_req;
  logic [9:0]  pc;
  logic        running;
  logic        done;
  logic [15:0] cycle_count;
  logic [1:0]  dbg_state;

  int checks;
  int errors;

  // Reference model: 0 = idle, 1 = running, 2 = halted.
  int m_state;
  int m_pc;
  int m_cnt;
  int m_lut [LUT_N];

  pc_unit #(.PC_W(PC_W), .LUT_N(LUT_N)) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .stall       (stall),
    .branch_en   (branch_en),
    .branch_cond (branch_cond),
    .equal       (equal),
    .lessThan    (less_than),
    .lut_idx     (lut_idx),
    .lut_we      (lut_we),
    .lut_waddr   (lut_waddr),
    .lut_wdata   (lut_wdata),
    .halt_req    (halt_req),
    .pc          (pc),
    .running     (running),
    .done        (done),
    .cycle_count (cycle_count),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".pc"}, 32'(pc), 32'(m_pc));
    check({tag, ".running"}, 32'(running), 32'(m_state == 1));
    check({tag, ".done"}, 32'(done), 32'(m_state == 2));
    check({tag, ".cycle_count"}, 32'(cycle_count), 32'(m_cnt));
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pc    = 0;
    m_cnt   = 0;
    for (int i = 0; i < LUT_N; i++) m_lut[i] = 0;
  endtask

  task automatic clear_inputs();
    start = 0; stall = 0; branch_en = 0; branch_cond = 2'b00;
    equal = 0; less_than = 0; lut_idx = 0; lut_we = 0;
    lut_waddr = 0; lut_wdata = 0; halt_req = 0;
  endtask

  // One clock edge with the currently driven inputs; model advances alongside.
  task automatic step(input string tag, input bit chk);
    int  n_state, n_pc, n_cnt;
    bit  cond_ok;
    n_state = m_state;
    n_pc    = m_pc;
    n_cnt   = m_cnt;
    if (m_state == 1) begin
      if (!stall) begin
        n_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        case (branch_cond)
          2'b00:   cond_ok = equal;
          2'b01:   cond_ok = less_than;
          2'b10:   cond_ok = equal || less_than;
          default: cond_ok = 1;
        endcase
        if (halt_req) n_state = 2;
        else if (branch_en && cond_ok) n_pc = m_lut[lut_idx];
        else n_pc = (m_pc + 1) % PC_MOD;
      end
    end else if (start) begin
      n_state = 1;
      n_pc    = 0;
      n_cnt   = 0;
    end
    @(posedge clk);
    if (lut_we) m_lut[lut_waddr] = int'(lut_wdata);
    m_state = n_state;
    m_pc    = n_pc;
    m_cnt   = n_cnt;
    #1;
    if (chk) check_outputs(tag);
  endtask

  task automatic write_lut(input int addr, input int data);
    lut_we = 1; lut_waddr = 4'(addr); lut_wdata = 10'(data);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    model_reset();
    reset_n = 0;
    #2;
    check_outputs("reset");
    @(negedge clk);
    reset_n = 1;

    // Idle ignores everything but start.
    branch_en = 1; branch_cond = 2'b11; halt_req = 1; stall = 1;
    step("idle_ignore", 1);
    clear_inputs();

    // Start, then five plain cycles.
    start = 1;
    step("start", 1);
    start = 0;
    for (int i = 0; i < 5; i++) step("seq", 1);
    check("seq5.pc", 32'(pc), 32'd5);
    check("seq5.count", 32'(cycle_count), 32'd5);

    // LTE branch via lut[3]; then LTE not taken.
    write_lut(3, 10'h12A);
    step("lutw3", 1);
    lut_we = 0;
    branch_en = 1; branch_cond = 2'b10; equal = 0; less_than = 1; lut_idx = 3;
    step("lte_taken", 1);
    check("lte_taken.const", 32'(pc), 32'h12A);
    less_than = 0;
    step("lte_not_taken", 1);
    check("lte_not_taken.const", 32'(pc), 32'h12B);

    // Reach the top address and wrap.
    clear_inputs();
    write_lut(5, 10'h3FF);
    step("lutw5", 1);
    clear_inputs();
    branch_en = 1; branch_cond = 2'b11; lut_idx = 5;
    step("to_top", 1);
    clear_inputs();
    step("wrap", 1);
    check("wrap.const", 32'(pc), 32'd0);

    // Stall masks halt; then halt; halted ignores inputs; start restarts.
    stall = 1; halt_req = 1;
    step("stall_halt1", 1);
    step("stall_halt2", 1);
    stall = 0;
    step("halt", 1);
    check("halt.done", 32'(done), 32'd1);
    branch_en = 1; branch_cond = 2'b11;
    for (int i = 0; i < 3; i++) step("halted_hold", 1);
    clear_inputs();
    start = 1;
    step("restart", 1);
    start = 0;
    check("restart.done", 32'(done), 32'd0);
    step("start_in_run_prep", 1);
    start = 1;
    step("start_in_run", 1);
    start = 0;

    // Same-cycle write and read of lut[2].
    write_lut(2, 10'h011);
    step("lutw2_old", 1);
    write_lut(2, 10'h055);
    branch_en = 1; branch_cond = 2'b11; lut_idx = 2;
    step("wr_rd_same", 1);
    check("wr_rd_same.const", 32'(pc), 32'h011);
    lut_we = 0;
    step("wr_rd_after", 1);
    check("wr_rd_after.const", 32'(pc), 32'h055);

    // Reset between edges mid-run.
    clear_inputs();
    step("pre_reset", 1);
    #2;
    reset_n = 0;
    #1;
    model_reset();
    check_outputs("async_reset");
    @(negedge clk);
    reset_n = 1;
    step("post_reset_idle", 1);
    start = 1;
    step("post_reset_start", 1);
    start = 0;
    branch_en = 1; branch_cond = 2'b11; lut_idx = 3;
    step("post_reset_lut_zero", 1);
    check("post_reset_lut_zero.const", 32'(pc), 32'd0);
    clear_inputs();

    // Randomised traffic.
    for (int i = 0; i < 500; i++) begin
      start       = ($urandom_range(0, 24) == 0);
      stall       = ($urandom_range(0, 4) == 0);
      halt_req    = ($urandom_range(0, 39) == 0);
      branch_en   = 1'($urandom_range(0, 1));
      branch_cond = 2'($urandom_range(0, 3));
      equal       = 1'($urandom_range(0, 1));
      less_than   = 1'($urandom_range(0, 1));
      lut_idx     = 4'($urandom_range(0, LUT_N - 1));
      lut_we      = ($urandom_range(0, 3) == 0);
      lut_waddr   = 4'($urandom_range(0, LUT_N - 1));
      lut_wdata   = 10'($urandom_range(0, PC_MOD - 1));
      step("rand", 1);
    end

    // Counter saturation.
    clear_inputs();
    if (m_state != 1) begin
      start = 1;
      step("sat_start", 1);
      start = 0;
    end
    for (int i = 0; i < 65540; i++) step("sat", 0);
    check_outputs("sat");
    check("sat.const", 32'(cycle_count), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
